axi4_lite_read_protocol_monitor: RTL and testbench
==================================================

# axi4_lite_read_protocol_monitor

Passive, parametrised AXI4-Lite read-channel checker and coverage monitor bound into the master read agent BFM. It observes the AR and R channels, enforces handshake stability, per-channel ready timeouts and per-transaction response latency across up to MAX_OUTSTANDING in-flight reads, and reports violations as registered pulses, sticky flags and counters. It supersedes the fixed delay constants used by the read-agent assertions: every limit is now a module parameter, and multiple outstanding transactions are tracked.

## Interface
- ADDR_WIDTH, 32, araddr width
- DATA_WIDTH, 32, rdata width (32 or 64)
- MAX_DELAY_READY, 16, max consecutive cycles VALID may wait for READY on AR or R
- MAX_DELAY_RVALID, 10, max cycles from AR handshake to matching R handshake
- MAX_OUTSTANDING, 4, tracked in-flight reads (power of 2, ≥1)
- DELAY_FOR_SECOND_TRANSFER, 16, window in cycles for back-to-back coverage
- CNT_WIDTH, 16, width of transfer counters
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- arvalid, arready  in  1  AR handshake
- araddr  in  ADDR_WIDTH  read address
- arprot  in  3  protection
- rvalid, rready  in  1  R handshake
- rdata  in  DATA_WIDTH  read data
- rresp  in  2  response
- err_pulse  out  7  one-cycle violation flags, bit map below
- err_sticky  out  7  OR-accumulated err_pulse, cleared only by reset
- first_err  out  3  index of first violation (lowest bit wins on tie), valid when err_sticky≠0
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current in-flight reads
- ar_count, r_count  out  CNT_WIDTH  completed AR / R handshakes, wrapping
- cov_b2b  out  1  pulse: AR handshake within window of previous one
- cov_slverr  out  1  pulse: R handshake with rresp=2'b10 or 2'b11

## Operation
- err bit map: [0] AR unstable, [1] R unstable, [2] AR ready timeout, [3] R ready timeout, [4] response latency timeout, [5] R with no outstanding AR, [6] AR beyond MAX_OUTSTANDING.
- AR stability: if previous cycle had arvalid && !arready, current cycle must have arvalid=1 and araddr, arprot unchanged; else bit 0.
- R stability: same rule on rvalid, rdata, rresp; bit 1.
- Ready timeout: per-channel wait counter increments each cycle VALID && !READY, clears on handshake or VALID low, saturates. Flag bit 2/3 once when counter reaches MAX_DELAY_READY+1; no re-flag until counter clears.
- Tracking: age FIFO of depth MAX_OUTSTANDING, each entry = saturating age counter + flagged bit. AR handshake pushes age 0; every cycle all valid entries increment; R handshake pops oldest.
- Latency timeout: oldest entry age reaching MAX_DELAY_RVALID+1 with flagged=0 → bit 4, set flagged. Only oldest entry is checked (in-order responses).
- R handshake with outstanding=0 → bit 5, no pop, r_count still increments.
- AR handshake with outstanding=MAX_OUTSTANDING and no same-cycle pop → bit 6, entry dropped, ar_count increments. Push and pop in same cycle when full is legal.
- Same-cycle AR and R handshakes with outstanding=0: bit 5 flagged, AR pushed.
- cov_b2b: gap counter cleared on AR handshake; cov_b2b pulses on an AR handshake when a prior AR handshake exists since reset and gap ≤ DELAY_FOR_SECOND_TRANSFER.

## Timing
- All outputs registered; every pulse/flag appears the cycle after the offending aclk edge.
- Reset: all outputs 0, FIFO empty, all counters 0, "prior AR" flag cleared. Reset mid-transaction discards all in-flight entries; first cycle after reset has no stability history (no bit 0/1 possible).
- outstanding and counters update the cycle after the handshake edge.
- first_err latches on the first cycle err_sticky becomes non-zero; never changes afterwards until reset.

## Test plan
- Single read, arready after 3 cycles, R 4 cycles after AR handshake, rresp=0 → err_sticky=0, ar_count=r_count=1, outstanding 1 then 0.
- araddr changes 0x100→0x104 while arvalid && !arready → err_pulse=7'b0000001 for one cycle, first_err=0, err_sticky holds.
- arvalid held 17 cycles with arready=0 (MAX_DELAY_READY=16) → bit 2 pulses once on the 18th cycle; no further pulse while still stalled.
- Four ARs back-to-back (MAX_OUTSTANDING=4), fifth AR before any R → bit 6; then 4 R at latency ≤10 → no bit 4, outstanding returns 0.
- AR then no R for 11 cycles (MAX_DELAY_RVALID=10) → bit 4 once; late R pops without bit 5; rvalid with nothing outstanding → bit 5.
- Two ARs 16 cycles apart → cov_b2b=1; 17 cycles apart → cov_b2b=0; R with rresp=2'b10 → cov_slverr=1; assert areset mid-flight → all outputs 0 next cycle.

Source files
------------

// File: rtl/axi4_lite_read_protocol_monitor.sv
// Passive AXI4-Lite read-channel checker: handshake stability, ready timeouts,
// in-order response latency over several outstanding reads, plus coverage pulses.
module axi4_lite_read_protocol_monitor #(
    parameter int ADDR_WIDTH                = 32,
    parameter int DATA_WIDTH                = 32,
    parameter int MAX_DELAY_READY           = 16,
    parameter int MAX_DELAY_RVALID          = 10,
    parameter int MAX_OUTSTANDING           = 4,
    parameter int DELAY_FOR_SECOND_TRANSFER = 16,
    parameter int CNT_WIDTH                 = 16
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic                               arvalid,
    input  logic                               arready,
    input  logic [ADDR_WIDTH-1:0]              araddr,
    input  logic [2:0]                         arprot,
    input  logic                               rvalid,
    input  logic                               rready,
    input  logic [DATA_WIDTH-1:0]              rdata,
    input  logic [1:0]                         rresp,
    output logic [6:0]                         err_pulse,
    output logic [6:0]                         err_sticky,
    output logic [2:0]                         first_err,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic [CNT_WIDTH-1:0]               ar_count,
    output logic [CNT_WIDTH-1:0]               r_count,
    output logic                               cov_b2b,
    output logic                               cov_slverr
);

    localparam int OUT_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int AGE_W  = $clog2(MAX_DELAY_RVALID + 2);
    localparam int WAIT_W = $clog2(MAX_DELAY_READY + 2);
    localparam int GAP_W  = $clog2(DELAY_FOR_SECOND_TRANSFER + 2);

    localparam logic [AGE_W-1:0]     AGE_SAT  = AGE_W'(MAX_DELAY_RVALID + 1);
    localparam logic [AGE_W-1:0]     AGE_LIM  = AGE_W'(MAX_DELAY_RVALID);
    localparam logic [AGE_W-1:0]     AGE_ONE  = AGE_W'(1);
    localparam logic [WAIT_W-1:0]    WAIT_SAT = WAIT_W'(MAX_DELAY_READY + 1);
    localparam logic [WAIT_W-1:0]    WAIT_LIM = WAIT_W'(MAX_DELAY_READY);
    localparam logic [WAIT_W-1:0]    WAIT_ONE = WAIT_W'(1);
    localparam logic [GAP_W-1:0]     GAP_SAT  = GAP_W'(DELAY_FOR_SECOND_TRANSFER + 1);
    localparam logic [GAP_W-1:0]     GAP_LIM  = GAP_W'(DELAY_FOR_SECOND_TRANSFER);
    localparam logic [GAP_W-1:0]     GAP_ONE  = GAP_W'(1);
    localparam logic [OUT_W-1:0]     OUT_FULL = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0]     OUT_ONE  = OUT_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // A transfer happens on any edge where VALID and READY are both high;
    // VALID must then stay high with stable payload until READY arrives.
    logic ar_hs, r_hs, ar_stall, r_stall;
    assign ar_hs    = arvalid && arready;
    assign r_hs     = rvalid && rready;
    assign ar_stall = arvalid && !arready;
    assign r_stall  = rvalid && !rready;

    logic                  ar_pend_q, r_pend_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [2:0]            arprot_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic [WAIT_W-1:0]     ar_wait_q, r_wait_q;
    logic [GAP_W-1:0]      gap_q;
    logic                  prior_q;

    // Age FIFO: slot 0 is the oldest, slots [0, count_q) are valid.
    logic [AGE_W-1:0]           age_q [MAX_OUTSTANDING];
    logic [AGE_W-1:0]           age_d [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] flag_q, flag_d;
    logic [OUT_W-1:0]           count_q, count_d, cnt_after;

    logic       lat_hit, pop, push, full_drop;
    logic [6:0] err_d;
    logic [2:0] first_d;

    always_comb begin
        lat_hit   = (count_q != '0) && !flag_q[0] && (age_q[0] >= AGE_LIM);
        pop       = r_hs && (count_q != '0);
        full_drop = ar_hs && (count_q == OUT_FULL) && !pop;
        push      = ar_hs && !full_drop;

        err_d    = '0;
        err_d[0] = ar_pend_q && (!arvalid || (araddr != araddr_q) || (arprot != arprot_q));
        err_d[1] = r_pend_q && (!rvalid || (rdata != rdata_q) || (rresp != rresp_q));
        err_d[2] = ar_stall && (ar_wait_q == WAIT_LIM);
        err_d[3] = r_stall && (r_wait_q == WAIT_LIM);
        err_d[4] = lat_hit;
        err_d[5] = r_hs && (count_q == '0);
        err_d[6] = full_drop;

        first_d = '0;
        for (int i = 6; i >= 0; i--) begin
            if (err_d[i]) first_d = 3'(i);
        end
    end

    always_comb begin
        age_d  = age_q;
        flag_d = flag_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if ((OUT_W'(i) < count_q) && (age_q[i] != AGE_SAT)) age_d[i] = age_q[i] + AGE_ONE;
        end
        if (lat_hit) flag_d[0] = 1'b1;
        cnt_after = count_q;
        if (pop) begin
            for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
                age_d[i]  = age_d[i+1];
                flag_d[i] = flag_d[i+1];
            end
            age_d[MAX_OUTSTANDING-1]  = '0;
            flag_d[MAX_OUTSTANDING-1] = 1'b0;
            cnt_after = count_q - OUT_ONE;
        end
        if (push) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (OUT_W'(i) == cnt_after) begin
                    age_d[i]  = '0;
                    flag_d[i] = 1'b0;
                end
            end
        end
        count_d = push ? cnt_after + OUT_ONE : cnt_after;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ar_pend_q   <= 1'b0;
            r_pend_q    <= 1'b0;
            araddr_q    <= '0;
            arprot_q    <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            ar_wait_q   <= '0;
            r_wait_q    <= '0;
            gap_q       <= '0;
            prior_q     <= 1'b0;
            flag_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) age_q[i] <= '0;
            err_pulse   <= '0;
            err_sticky  <= '0;
            first_err   <= '0;
            outstanding <= '0;
            ar_count    <= '0;
            r_count     <= '0;
            cov_b2b     <= 1'b0;
            cov_slverr  <= 1'b0;
        end else begin
            ar_pend_q <= ar_stall;
            r_pend_q  <= r_stall;
            araddr_q  <= araddr;
            arprot_q  <= arprot;
            rdata_q   <= rdata;
            rresp_q   <= rresp;

            // Wait counters park at limit+1 so each stall flags only once.
            if (!ar_stall)                ar_wait_q <= '0;
            else if (ar_wait_q != WAIT_SAT) ar_wait_q <= ar_wait_q + WAIT_ONE;
            if (!r_stall)                 r_wait_q <= '0;
            else if (r_wait_q != WAIT_SAT)  r_wait_q <= r_wait_q + WAIT_ONE;

            // gap_q reads k on the edge k cycles after the last AR transfer.
            if (ar_hs)                 gap_q <= GAP_ONE;
            else if (gap_q != GAP_SAT) gap_q <= gap_q + GAP_ONE;
            if (ar_hs) prior_q <= 1'b1;

            age_q   <= age_d;
            flag_q  <= flag_d;
            count_q <= count_d;

            err_pulse  <= err_d;
            err_sticky <= err_sticky | err_d;
            if ((err_sticky == '0) && (err_d != '0)) first_err <= first_d;

            outstanding <= count_d;
            if (ar_hs) ar_count <= ar_count + CNT_ONE;
            if (r_hs)  r_count  <= r_count + CNT_ONE;
            cov_b2b    <= ar_hs && prior_q && (gap_q <= GAP_LIM);
            cov_slverr <= r_hs && rresp[1];
        end
    end

endmodule

// File: tb/tb_axi4_lite_read_protocol_monitor.sv
// Bench for the read protocol monitor: directed scenarios plus random traffic,
// every cycle scored against a queue/arithmetic reference model.
module tb_axi4_lite_read_protocol_monitor;

    localparam int MAX_DELAY_READY  = 16;
    localparam int MAX_DELAY_RVALID = 10;
    localparam int MAX_OUTSTANDING  = 4;
    localparam int B2B_WIN          = 16;
    localparam int OUT_W            = $clog2(MAX_OUTSTANDING) + 1;

    typedef struct packed {
        logic [6:0]       pulse;
        logic [6:0]       sticky;
        logic [2:0]       first;
        logic [OUT_W-1:0] outst;
        logic [15:0]      arc;
        logic [15:0]      rc;
        logic             b2b;
        logic             slv;
    } obs_t;
    localparam int OBS_W = $bits(obs_t);

    logic             aclk, areset;
    logic             arvalid, arready, rvalid, rready;
    logic [31:0]      araddr, rdata;
    logic [2:0]       arprot;
    logic [1:0]       rresp;
    logic [6:0]       err_pulse, err_sticky;
    logic [2:0]       first_err;
    logic [OUT_W-1:0] outstanding;
    logic [15:0]      ar_count, r_count;
    logic             cov_b2b, cov_slverr;

    axi4_lite_read_protocol_monitor #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .MAX_DELAY_READY(MAX_DELAY_READY), .MAX_DELAY_RVALID(MAX_DELAY_RVALID),
        .MAX_OUTSTANDING(MAX_OUTSTANDING), .DELAY_FOR_SECOND_TRANSFER(B2B_WIN),
        .CNT_WIDTH(16)
    ) dut (
        .aclk(aclk), .areset(areset),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .err_pulse(err_pulse), .err_sticky(err_sticky), .first_err(first_err),
        .outstanding(outstanding), .ar_count(ar_count), .r_count(r_count),
        .cov_b2b(cov_b2b), .cov_slverr(cov_slverr)
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic [OBS_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model: outstanding reads are a queue of issue times
    int          m_push_t[$];
    bit          m_flag[$];
    int          m_ar_len, m_r_len, m_last_ar;
    bit          m_ar_pend, m_r_pend, m_prior, m_ar_hs, m_r_hs;
    logic [31:0] m_araddr, m_rdata;
    logic [2:0]  m_arprot;
    logic [1:0]  m_rresp;
    logic [6:0]  m_sticky, m_p;
    logic [2:0]  m_first;
    logic [15:0] m_arc, m_rc;
    obs_t        m_e;

    always @(posedge aclk) begin
        m_e = '0;
        if (areset) begin
            m_push_t.delete();
            m_flag.delete();
            m_ar_len = 0; m_r_len = 0; m_ar_pend = 0; m_r_pend = 0;
            m_sticky = '0; m_first = '0; m_arc = '0; m_rc = '0; m_prior = 0;
        end else begin
            m_ar_hs = arvalid && arready;
            m_r_hs  = rvalid && rready;
            m_p = '0;
            if (m_ar_pend && (!arvalid || araddr !== m_araddr || arprot !== m_arprot)) m_p[0] = 1'b1;
            if (m_r_pend && (!rvalid || rdata !== m_rdata || rresp !== m_rresp)) m_p[1] = 1'b1;
            if (arvalid && !arready) begin
                m_ar_len++;
                if (m_ar_len == MAX_DELAY_READY + 1) m_p[2] = 1'b1;
            end else m_ar_len = 0;
            if (rvalid && !rready) begin
                m_r_len++;
                if (m_r_len == MAX_DELAY_READY + 1) m_p[3] = 1'b1;
            end else m_r_len = 0;
            if (m_push_t.size() > 0 && !m_flag[0] && (cyc - m_push_t[0]) > MAX_DELAY_RVALID) begin
                m_p[4] = 1'b1;
                m_flag[0] = 1'b1;
            end
            if (m_r_hs) begin
                if (m_push_t.size() == 0) m_p[5] = 1'b1;
                else begin
                    void'(m_push_t.pop_front());
                    void'(m_flag.pop_front());
                end
            end
            if (m_ar_hs) begin
                if (m_push_t.size() == MAX_OUTSTANDING) m_p[6] = 1'b1;
                else begin
                    m_push_t.push_back(cyc);
                    m_flag.push_back(1'b0);
                end
            end
            if (m_ar_hs) m_arc++;
            if (m_r_hs) m_rc++;
            m_e.b2b = m_ar_hs && m_prior && ((cyc - m_last_ar) <= B2B_WIN);
            if (m_ar_hs) begin
                m_prior   = 1;
                m_last_ar = cyc;
            end
            m_e.slv = m_r_hs && rresp[1];
            if (m_sticky == '0 && m_p != '0) begin
                for (int i = 6; i >= 0; i--) if (m_p[i]) m_first = 3'(i);
            end
            m_sticky = m_sticky | m_p;
            m_e.pulse  = m_p;
            m_e.sticky = m_sticky;
            m_e.first  = m_first;
            m_e.outst  = OUT_W'(m_push_t.size());
            m_e.arc    = m_arc;
            m_e.rc     = m_rc;
            m_ar_pend = arvalid && !arready;
            m_r_pend  = rvalid && !rready;
            m_araddr = araddr; m_arprot = arprot; m_rdata = rdata; m_rresp = rresp;
        end
        cyc++;
        exp_q.push_back(m_e);
    end

    // scoreboard monitor: one expected observation per clock
    always @(negedge aclk) begin
        obs_t e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {err_pulse, err_sticky, first_err, outstanding, ar_count, r_count, cov_b2b, cov_slverr};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: pulse %b/%b sticky %b/%b first %0d/%0d outst %0d/%0d arc %0d/%0d rc %0d/%0d b2b %b/%b slverr %b/%b (got/required)",
                         $time, a.pulse, e.pulse, a.sticky, e.sticky, a.first, e.first, a.outst, e.outst,
                         a.arc, e.arc, a.rc, e.rc, a.b2b, e.b2b, a.slv, e.slv);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        arvalid = 0; arready = 0; rvalid = 0; rready = 0;
    endtask

    task automatic do_reset();
        idle();
        areset = 1;
        step();
        step();
        areset = 0;
    endtask

    task automatic ar_once(input logic [31:0] addr);
        arvalid = 1; arready = 1; araddr = addr; arprot = 3'($urandom_range(7));
        step();
        arvalid = 0; arready = 0;
    endtask

    task automatic r_once(input logic [1:0] resp);
        rvalid = 1; rready = 1; rdata = $urandom; rresp = resp;
        step();
        rvalid = 0; rready = 0;
    endtask

    task automatic run_random(input int n, input int rdy_pct, input int rv_pct, input int viol_pct);
        repeat (n) begin
            if (!(arvalid && !arready) || $urandom_range(99) < viol_pct) begin
                arvalid = ($urandom_range(99) < 50);
                araddr  = 32'($urandom_range(3)) << 2;
                arprot  = 3'($urandom_range(7));
            end
            arready = ($urandom_range(99) < rdy_pct);
            if (!(rvalid && !rready) || $urandom_range(99) < viol_pct) begin
                rvalid = ($urandom_range(99) < rv_pct);
                rdata  = 32'($urandom_range(3));
                rresp  = 2'($urandom_range(3));
            end
            rready = ($urandom_range(99) < rdy_pct);
            areset = ($urandom_range(499) == 0);
            step();
        end
        areset = 0;
    endtask

    initial begin
        areset = 1; idle();
        araddr = '0; arprot = '0; rdata = '0; rresp = '0;
        step();
        chk("reset_pulse", 32'(err_pulse), 0);
        chk("reset_outstanding", 32'(outstanding), 0);
        do_reset();

        // single clean read
        arvalid = 1; arready = 0; araddr = 32'h10; arprot = 0;
        repeat (3) step();
        arready = 1;
        step();
        idle();
        chk("single_outst_1", 32'(outstanding), 1);
        repeat (3) step();
        r_once(2'b00);
        chk("single_outst_0", 32'(outstanding), 0);
        chk("single_counts", {ar_count, r_count}, {16'd1, 16'd1});
        chk("single_sticky", 32'(err_sticky), 0);

        // address changes during a stall
        do_reset();
        arvalid = 1; arready = 0; araddr = 32'h100; arprot = 0;
        step();
        araddr = 32'h104;
        step();
        chk("ar_unstable_pulse", 32'(err_pulse), 32'b0000001);
        chk("ar_unstable_first", 32'(first_err), 0);
        step();
        chk("ar_unstable_once", 32'(err_pulse), 0);
        chk("ar_unstable_sticky", 32'(err_sticky), 32'b0000001);
        arready = 1;
        step();
        idle();

        // AR ready timeout
        do_reset();
        arvalid = 1; arready = 0; araddr = 32'h20;
        repeat (16) step();
        chk("ar_timeout_early", 32'(err_pulse), 0);
        step();
        chk("ar_timeout_pulse", 32'(err_pulse), 32'b0000100);
        repeat (5) begin
            step();
            chk("ar_timeout_no_reflag", 32'(err_pulse), 0);
        end
        arready = 1;
        step();
        idle();

        // overflow of outstanding tracking, then drain
        do_reset();
        arvalid = 1; arready = 1;
        for (int i = 0; i < 5; i++) begin
            araddr = 32'(i * 4);
            step();
            if (i == 3) chk("full_outst", 32'(outstanding), 4);
        end
        chk("overflow_pulse", 32'(err_pulse), 32'b1000000);
        chk("overflow_arc", 32'(ar_count), 5);
        arvalid = 0; arready = 0; rvalid = 1; rready = 1; rresp = 0;
        repeat (4) step();
        idle();
        chk("drain_outst", 32'(outstanding), 0);
        chk("drain_sticky", 32'(err_sticky), 32'b1000000);

        // response latency timeout, late R, orphan R
        do_reset();
        ar_once(32'h40);
        repeat (10) begin
            step();
            chk("latency_quiet", 32'(err_pulse), 0);
        end
        step();
        chk("latency_pulse", 32'(err_pulse), 32'b0010000);
        step();
        chk("latency_once", 32'(err_pulse), 0);
        r_once(2'b00);
        chk("late_r_pulse", 32'(err_pulse), 0);
        chk("late_r_outst", 32'(outstanding), 0);
        r_once(2'b00);
        chk("orphan_r_pulse", 32'(err_pulse), 32'b0100000);
        chk("orphan_first", 32'(first_err), 4);

        // back-to-back window, slave error, mid-flight reset
        do_reset();
        ar_once(32'h0);
        repeat (15) step();
        ar_once(32'h4);
        chk("b2b_16", 32'(cov_b2b), 1);
        repeat (16) step();
        ar_once(32'h8);
        chk("b2b_17", 32'(cov_b2b), 0);
        r_once(2'b10);
        chk("slverr", 32'(cov_slverr), 1);
        ar_once(32'hC);
        areset = 1; arvalid = 1; arready = 0;
        step();
        chk("midreset_all", {err_pulse, err_sticky, first_err, outstanding, cov_b2b, cov_slverr}, 0);
        chk("midreset_counts", {ar_count, r_count}, 0);
        areset = 0;
        araddr = 32'h44;
        step();
        chk("post_reset_no_stab", 32'(err_pulse), 0);
        idle();

        // randomized traffic
        do_reset();
        run_random(700, 70, 30, 5);
        do_reset();
        run_random(700, 5, 10, 0);
        do_reset();
        run_random(700, 90, 20, 0);
        do_reset();
        run_random(700, 60, 40, 10);

        idle();
        repeat (3) step();
        @(negedge aclk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
